// File: rtl/tqvp_add_seq.sv
// ---------------------------------------------------------------------------
// tqvp_add_seq -- memory-mapped add sequencer for the TinyQV peripheral bus.
//
// The CPU queues 16+16-bit operand pairs into a 4-entry job FIFO. A small FSM
// feeds one job at a time through a shared nibble-serial adder (4 nibble
// cycles per job). Each 17-bit sum lands in a 4-entry result FIFO, which the
// CPU pops by reading RESULT. An interrupt is raised while results are pending.
//
// Register map (byte address):
//   0x00 JOB    W: 32-bit write pushes {b[31:16], a[15:0]}; narrower writes
//               are ignored. Reads 0.
//   0x04 RESULT R: {15'h0, sum[16:0]} of the result FIFO head; a read strobe
//               pops it. An empty read returns 0 and sets err_udf.
//   0x08 STATUS R: [2:0] job_count, [6:4] res_count, [8] busy, [9] err_ovf,
//               [10] err_udf, [16] irq_en.
//   0x0C CTRL   W: [0] irq_en, [1] clear errors, [2] flush. R: {31'h0, irq_en}.
//
// Ports:
//   clk             project clock
//   rst             asynchronous, active-high reset
//   address[5:0]    register select
//   data_in[31:0]   write data
//   data_write_n    11 none, 00 8-bit, 01 16-bit, 10 32-bit
//   data_read_n     11 none, otherwise a one-cycle read strobe
//   data_out[31:0]  read data, combinational from address
//   data_ready      always 1; every access completes in one cycle
//   user_interrupt  irq_en AND result FIFO non-empty
// ---------------------------------------------------------------------------
module tqvp_add_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam logic [5:0] ADDR_JOB    = 6'h00;
    localparam logic [5:0] ADDR_RESULT = 6'h04;
    localparam logic [5:0] ADDR_STATUS = 6'h08;
    localparam logic [5:0] ADDR_CTRL   = 6'h0C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state, state_next;

    // Job FIFO: {b, a} operand pairs.
    logic [31:0] job_mem [4];
    logic [1:0]  job_wr_ptr, job_rd_ptr;
    logic [2:0]  job_count;

    // Result FIFO: 17-bit sums.
    logic [16:0] res_mem [4];
    logic [1:0]  res_wr_ptr, res_rd_ptr;
    logic [2:0]  res_count;

    // Serial adder datapath.
    logic [15:0] op_a, op_b, sum_s;
    logic        carry;
    logic [1:0]  nib;
    logic [4:0]  nib_sum;

    logic        irq_en, err_ovf, err_udf;

    logic        job_wr, ctrl_wr, res_rd, flush, err_clr;
    logic        job_full, job_empty, res_full, res_empty;
    logic        job_push, job_pop, res_push, res_pop;
    logic        ovf_set, udf_set;
    logic [31:0] job_head;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign job_wr  = (data_write_n == 2'b10) && (address == ADDR_JOB);
    assign ctrl_wr = (data_write_n != 2'b11) && (address == ADDR_CTRL);
    assign res_rd  = (data_read_n  != 2'b11) && (address == ADDR_RESULT);
    assign flush   = ctrl_wr && data_in[2];
    assign err_clr = ctrl_wr && data_in[1];

    assign job_full  = (job_count == 3'd4);
    assign job_empty = (job_count == 3'd0);
    assign res_full  = (res_count == 3'd4);
    assign res_empty = (res_count == 3'd0);

    // Flush wins over every same-cycle push, pop and error set.
    assign job_push = job_wr && !job_full  && !flush;
    assign ovf_set  = job_wr &&  job_full  && !flush;
    assign res_pop  = res_rd && !res_empty && !flush;
    assign udf_set  = res_rd &&  res_empty && !flush;
    assign res_push = (state == ST_DONE) && !flush;

    assign job_head = job_mem[job_rd_ptr];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: state and all other flops use non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // A job may only start from IDLE, where nothing is in flight, so a free
    // result slot is guaranteed by res_count < 4 alone.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        job_pop    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!job_empty && !res_full) begin
                    state_next = ST_ADD;
                    job_pop    = 1'b1;
                end
            end
            ST_ADD:  if (nib == 2'd3) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
            job_pop    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Nibble-serial adder: low nibble first, sum shifted in from the top.
    // ------------------------------------------------------------------
    assign nib_sum = {1'b0, op_a[3:0]} + {1'b0, op_b[3:0]} + {4'b0, carry};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            sum_s <= '0;
            carry <= 1'b0;
            nib   <= '0;
        end else if (job_pop) begin
            op_a  <= job_head[15:0];
            op_b  <= job_head[31:16];
            carry <= 1'b0;
            nib   <= '0;
        end else if (state == ST_ADD) begin
            sum_s <= {nib_sum[3:0], sum_s[15:4]};
            op_a  <= {4'h0, op_a[15:4]};
            op_b  <= {4'h0, op_b[15:4]};
            carry <= nib_sum[4];
            nib   <= nib + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage arrays carry no reset; an entry is only ever read
    // after it was written, and RESULT reads are gated by res_empty.
    always_ff @(posedge clk) begin
        if (job_push) job_mem[job_wr_ptr] <= data_in;
        if (res_push) res_mem[res_wr_ptr] <= {carry, sum_s};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_wr_ptr <= '0;
            job_rd_ptr <= '0;
            job_count  <= '0;
        end else if (flush) begin
            job_wr_ptr <= '0;
            job_rd_ptr <= '0;
            job_count  <= '0;
        end else begin
            if (job_push) job_wr_ptr <= job_wr_ptr + 2'd1;
            if (job_pop)  job_rd_ptr <= job_rd_ptr + 2'd1;
            case ({job_push, job_pop})
                2'b10:   job_count <= job_count + 3'd1;
                2'b01:   job_count <= job_count - 3'd1;
                default: job_count <= job_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_count  <= '0;
        end else if (flush) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_count  <= '0;
        end else begin
            if (res_push) res_wr_ptr <= res_wr_ptr + 2'd1;
            if (res_pop)  res_rd_ptr <= res_rd_ptr + 2'd1;
            case ({res_push, res_pop})
                2'b10:   res_count <= res_count + 3'd1;
                2'b01:   res_count <= res_count - 3'd1;
                default: res_count <= res_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control and error flags
    // ------------------------------------------------------------------
    // A clear and a new error in the same cycle leave the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en  <= 1'b0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= data_in[0];
            err_ovf <= (err_ovf && !err_clr) || ovf_set;
            err_udf <= (err_udf && !err_clr) || udf_set;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------
    always_comb begin
        data_out = '0;
        case (address)
            ADDR_RESULT: if (!res_empty) data_out = {15'h0, res_mem[res_rd_ptr]};
            ADDR_STATUS: data_out = {15'h0, irq_en, 5'h0, err_udf, err_ovf,
                                     (state != ST_IDLE), 1'b0, res_count,
                                     1'b0, job_count};
            ADDR_CTRL:   data_out = {31'h0, irq_en};
            default:     data_out = '0;
        endcase
    end

    assign data_ready     = 1'b1;
    assign user_interrupt = irq_en && !res_empty;

endmodule

// File: doc/tqvp_add_seq.md
# tqvp_add_seq

Memory-mapped add sequencer for the TinyQV peripheral bus. It owns a single shared nibble-serial 16-bit adder and schedules jobs through it: the CPU queues operand pairs into a 4-entry job FIFO, and the FSM feeds them to the adder one at a time. 17-bit sums go to a 4-entry result FIFO that the CPU pops by reading. An interrupt is raised while results are pending.

## Interface
- No parameters; FIFO depth is fixed at 4 and operand width at 16.
- clk  in  1  project clock (64 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- address  in  6  register select: 0x00 JOB, 0x04 RESULT, 0x08 STATUS, 0x0C CTRL
- data_in  in  32  write data
- data_write_n  in  2  11 none, 00 8-bit, 01 16-bit, 10 32-bit
- data_read_n  in  2  11 none, otherwise read strobe (one cycle per access)
- data_out  out  32  read data, combinational from address
- data_ready  out  1  tied 1; all accesses complete in one cycle
- user_interrupt  out  1  high while irq_en=1 and the result FIFO is non-empty

## Operation
- **JOB (0x00, write-only, reads 0):**
  - A 32-bit write pushes {b=data_in[31:16], a=data_in[15:0]}.
  - 8-bit and 16-bit writes are ignored with no error.
  - A push while the job FIFO is full is dropped and sets err_ovf.
- **RESULT (0x04):**
  - data_out = {15'h0, head[16:0]}, where head is the result FIFO head.
  - A read strobe pops the head.
  - A read while the FIFO is empty returns 0 and sets err_udf.
- **STATUS (0x08, read-only):**
  - [2:0] job_count, 0..4
  - [6:4] res_count, 0..4
  - [8] busy (FSM not in IDLE)
  - [9] err_ovf
  - [10] err_udf
  - [16] irq_en
  - All other bits 0.
- **CTRL (0x0C):** accepts any write width.
  - data_in[0] → irq_en.
  - data_in[1]=1 clears err_ovf and err_udf.
  - data_in[2]=1 is a flush: it empties both FIFOs and forces the FSM to IDLE, discarding any in-flight job.
  - Reading CTRL returns {31'h0, irq_en}.
- Any other address reads 0; writes to it are ignored.
- **FSM states:** IDLE, ADD, DONE.
  - IDLE → ADD when job_count≠0 and res_count + busy-slot < 4, i.e. a result slot is guaranteed. This pops the job head into the operand shift registers A and B, clears carry, and sets nib=0.
  - ADD: each cycle computes {carry, sum_nib} = A[3:0] + B[3:0] + carry, shifts the sum into S[15:12], shifts A and B right by 4, and increments nib.
  - ADD → DONE after nib=3.
  - DONE: pushes {carry, S} into the result FIFO, then goes to IDLE.
- **Arithmetic:** unsigned, 16+16 → 17 bits; bit 16 is the carry out. There is no wrap loss.
- **Simultaneous events:**
  - A CPU job push and an FSM job pop in the same cycle both take effect; count is unchanged.
  - An FSM result push and a CPU result pop in the same cycle both take effect. If the FIFO was empty, the read returns 0, sets err_udf, and the push still lands.
  - Flush beats any same-cycle push or pop, and also any same-cycle err set caused by that access.
  - A CTRL error clear in the same cycle as a new error event leaves the flag set.
- **FIFO pointers:** 2-bit wrap-around pointers; counts are 3 bits.

## Timing
- **Reset (async assert):**
  - FIFOs empty, pointers 0, FSM IDLE.
  - irq_en=0, err flags 0, user_interrupt=0.
  - data_out follows address, so it reads 0 for empty/cleared registers. data_ready=1.
- **Job latency:** a job pushed at edge N is popped at N+1. ADD occupies edges N+2..N+5, DONE pushes at N+6, and the result is readable in the cycle after N+6.
- **Throughput:** one job per 6 cycles (IDLE, ADD×4, DONE). Back-to-back jobs re-enter ADD at the edge after DONE's IDLE cycle.
- **Back-pressure:** with the result FIFO full (res_count=4), the FSM stalls in IDLE and jobs remain queued.
- **Flush during ADD:** the FSM is in IDLE at the next edge and no result is pushed.
- **Interrupt timing:** user_interrupt is combinational from flops. It rises in the cycle after the DONE edge and falls in the cycle after the pop that empties the FIFO.

## Test plan
- **Single add:** reset, then write 32-bit 0x0001_FFFF to JOB. Wait 7 cycles; RESULT reads 0x0001_0000, and STATUS res_count goes 1→0 after the read.
- **Queue and back-pressure:** write 6 jobs (a=i, b=i+0x100, i=0..5) with no reads.
  - Job 5 sets err_ovf.
  - After 40 cycles STATUS=0x0000_0241: res=4, job=1, busy=0, err_ovf=1.
  - Reading 4 results gives 0x100, 0x102, 0x104, 0x106; the remaining queued job then completes as 0x108.
- **Underflow:** read RESULT while empty → reads 0 and err_udf=1. A CTRL write of 0x2 clears it, and STATUS reads 0.
- **Interrupt:**
  - Write CTRL=0x1, push job 0x1234_4321; user_interrupt rises 7 cycles later and RESULT=0x05555.
  - Read RESULT; the interrupt drops the next cycle.
  - With irq_en=0 the interrupt stays low throughout.
- **Flush mid-operation:** push 0xFFFF_FFFF, and write CTRL=0x4 on the 3rd ADD cycle. Then busy=0 and res_count=0, no result ever appears, and a subsequent job 0x0002_0003 returns 0x5.
- **Async reset mid-ADD:** assert rst between edges. All outputs clear immediately, and STATUS reads 0 after release.
